// File: rtl/scan_ctrl.sv
`timescale 1ns/1ps
// Scan test controller for a single chain of scanff cells: shift in a pattern,
// run one capture cycle, shift the response out and compare it with the expected vector.
module scan_ctrl #(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expected_in,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response
);

    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LastCnt = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StCapture,
        StShiftOut,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
    logic [CHAIN_LEN-1:0] expected_q, expected_d;
    logic [CHAIN_LEN-1:0] response_q, response_d;
    logic                 pass_q, pass_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pattern_d  = pattern_q;
        expected_d = expected_q;
        response_d = response_q;
        pass_d     = pass_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    pattern_d  = pattern_in;
                    expected_d = expected_in;
                    cnt_d      = '0;
                    pass_d     = 1'b0;
                    state_d    = StShiftIn;
                end
            end
            StShiftIn: begin
                // MSB leaves first, so after CHAIN_LEN shifts cell k holds pattern[k]
                pattern_d = {pattern_q[CHAIN_LEN-2:0], 1'b0};
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCapture: begin
                state_d = StShiftOut;
            end
            StShiftOut: begin
                for (int k = 0; k < CHAIN_LEN; k++) begin
                    if (CW'(CHAIN_LEN - 1 - k) == cnt_q) begin
                        response_d[k] = scan_out;
                    end
                end
                if (cnt_q == LastCnt) begin
                    // Compare against the fully assembled response so pass is valid with done
                    pass_d  = (response_d == expected_q);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pattern_q  <= '0;
            expected_q <= '0;
            response_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pattern_q  <= pattern_d;
            expected_q <= expected_d;
            response_q <= response_d;
            pass_q     <= pass_d;
        end
    end

    assign scan_en  = (state_q == StShiftIn) || (state_q == StShiftOut);
    assign scan_in  = (state_q == StShiftIn) && pattern_q[CHAIN_LEN-1];
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign pass     = pass_q;
    assign response = response_q;

endmodule

// File: tb/tb_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for scan_ctrl driving a behavioural 8-cell scan chain
// whose functional inputs are either a constant or each cell's own output.
module tb_scan_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] pattern_in;
    logic [7:0] expected_in;
    logic       scan_out;
    logic       scan_en;
    logic       scan_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] response;

    logic [7:0] chain;
    logic       loopback;

    int checks;
    int errors;

    logic [22:0] en_tr, si_tr, busy_tr;
    int          done_cnt, done_cyc;
    logic        pass_at_done;
    logic        rst_busy, rst_en, rst_pass;
    logic [7:0]  rst_resp;

    scan_ctrl #(.CHAIN_LEN(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pattern_in  (pattern_in),
        .expected_in (expected_in),
        .scan_out    (scan_out),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .response    (response)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cell 0 takes scan_in; cell 7 drives scan_out
    always @(posedge clock) begin
        if (scan_en) chain <= {chain[6:0], scan_in};
        else         chain <= loopback ? chain : 8'hA5;
    end
    assign scan_out = chain[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; cycle c is sampled at the c-th negedge after acceptance
    task automatic run_test(input logic [7:0] pat, input logic [7:0] exp,
                            input int start_a, input int start_b, input int rst_at);
        en_tr = '0; si_tr = '0; busy_tr = '0;
        done_cnt = 0; done_cyc = 0; pass_at_done = 1'b0;
        pattern_in = pat;
        expected_in = exp;
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clock);
            en_tr[c]   = scan_en;
            si_tr[c]   = scan_in;
            busy_tr[c] = busy;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                pass_at_done = pass;
            end
            if (rst_at != 0 && c == rst_at + 1) begin
                rst_busy = busy;
                rst_en   = scan_en;
                rst_resp = response;
                rst_pass = pass;
            end
            start = (c == start_a) || (c == start_b);
            reset = (c == rst_at);
            if (c == 1) begin
                pattern_in  = ~pat;
                expected_in = ~exp;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        pattern_in = '0;
        expected_in = '0;
        loopback = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_scan_en", 32'(scan_en), 32'd0);
        check("rst_scan_in", 32'(scan_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_response", 32'(response), 32'd0);
        reset = 1'b0;

        // Constant capture
        run_test(8'h00, 8'hA5, 0, 0, 0);
        check("const_response", 32'(response), 32'hA5);
        check("const_pass_at_done", 32'(pass_at_done), 32'd1);
        check("const_pass_hold", 32'(pass), 32'd1);
        check("const_done_count", 32'(done_cnt), 32'd1);
        check("const_done_cycle", 32'(done_cyc), 32'd18);

        // Mismatch
        run_test(8'h00, 8'hA4, 0, 0, 0);
        check("mism_response", 32'(response), 32'hA5);
        check("mism_pass", 32'(pass), 32'd0);

        // Loopback
        loopback = 1'b1;
        run_test(8'h3C, 8'h3C, 0, 0, 0);
        check("loop3c_response", 32'(response), 32'h3C);
        check("loop3c_pass", 32'(pass), 32'd1);
        run_test(8'h81, 8'h81, 0, 0, 0);
        check("loop81_response", 32'(response), 32'h81);
        check("loop81_pass", 32'(pass), 32'd1);

        // Waveform: scan_en high in cycles 1-8 and 10-17; scan_in 1,1,0,0,0,0,0,1 in 1-8
        run_test(8'hC1, 8'hC1, 0, 0, 0);
        check("wave_scan_en", 32'(en_tr), 32'h3FDFE);
        check("wave_scan_in", 32'(si_tr), 32'h106);
        check("wave_response", 32'(response), 32'hC1);

        // Start pulses during SHIFT_IN and during DONE are ignored
        run_test(8'h96, 8'h96, 3, 18, 0);
        check("ign_done_cycle", 32'(done_cyc), 32'd18);
        check("ign_done_count", 32'(done_cnt), 32'd1);
        check("ign_response", 32'(response), 32'h96);
        check("ign_pass", 32'(pass), 32'd1);
        check("ign_busy_trace", 32'(busy_tr), 32'h7FFFE);

        // Reset during SHIFT_OUT cycle 4 (cycle 13 after acceptance)
        run_test(8'h3C, 8'h3C, 0, 0, 13);
        check("rstmid_busy", 32'(rst_busy), 32'd0);
        check("rstmid_scan_en", 32'(rst_en), 32'd0);
        check("rstmid_response", 32'(rst_resp), 32'd0);
        check("rstmid_pass", 32'(rst_pass), 32'd0);
        check("rstmid_no_done", 32'(done_cnt), 32'd0);

        run_test(8'h5A, 8'h5A, 0, 0, 0);
        check("post_rst_response", 32'(response), 32'h5A);
        check("post_rst_pass", 32'(pass), 32'd1);
        check("post_rst_done_cycle", 32'(done_cyc), 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
